// File: rtl/riscv_32i_defs_pkg.sv
// riscv_32i_defs_pkg: shared RV32I widths and operand-fetch request/response types
package riscv_32i_defs_pkg;
  localparam int XLEN = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  typedef logic [RF_DEPTH-1:0] sb_vec_t;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rd_we;
  } opf_req_t;
  typedef struct packed {
    word_t     rs1_data;
    word_t     rs2_data;
    reg_addr_t rd;
    logic      rd_we;
  } opf_rsp_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async read ports, one write port, x0 hardwired to zero
module reg_file
  import riscv_32i_defs_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t i_raddr1,
  input  reg_addr_t i_raddr2,
  output word_t     o_rdata1,
  output word_t     o_rdata2,
  input  logic      i_we,
  input  reg_addr_t i_waddr,
  input  word_t     i_wdata
);
  word_t r_mem [RF_DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: RV32I operand read stage with write scoreboard, RAW/WAW stall,
// writeback bypass and a single-entry valid/ready output register.
module operand_fetch
  import riscv_32i_defs_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  reg_addr_t in_rs1,
  input  reg_addr_t in_rs2,
  input  reg_addr_t in_rd,
  input  logic      in_rd_we,
  output logic      out_valid,
  input  logic      out_ready,
  output word_t     out_rs1_data,
  output word_t     out_rs2_data,
  output reg_addr_t out_rd,
  output logic      out_rd_we,
  input  logic      wb_valid,
  input  reg_addr_t wb_rd,
  input  word_t     wb_data,
  output sb_vec_t   sb_busy
);
  opf_req_t w_req;
  opf_rsp_t w_rsp, r_rsp;
  sb_vec_t  r_sb, w_wb_mask, w_set_mask;
  word_t    w_rd1, w_rd2;
  logic     r_ov, w_clr1, w_clr2, w_clrd, w_raw, w_waw, w_acc;

  assign w_req = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_we: in_rd_we};

  reg_file u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_req.rs1),
    .i_raddr2 (w_req.rs2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .i_we     (wb_valid),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data)
  );

  // A writeback landing this cycle resolves the hazard only when forwarding is enabled
  assign w_clr1 = BYPASS_EN && wb_valid && (wb_rd == w_req.rs1);
  assign w_clr2 = BYPASS_EN && wb_valid && (wb_rd == w_req.rs2);
  assign w_clrd = BYPASS_EN && wb_valid && (wb_rd == w_req.rd);
  assign w_raw  = (w_req.rs1 != '0 && r_sb[w_req.rs1] && !w_clr1) ||
                  (w_req.rs2 != '0 && r_sb[w_req.rs2] && !w_clr2);
  assign w_waw  = w_req.rd_we && w_req.rd != '0 && r_sb[w_req.rd] && !w_clrd;
  assign in_ready = (!r_ov || out_ready) && !w_raw && !w_waw;
  assign w_acc    = in_valid && in_ready;

  assign w_rsp.rs1_data = (w_req.rs1 == '0) ? '0 : w_clr1 ? wb_data : w_rd1;
  assign w_rsp.rs2_data = (w_req.rs2 == '0) ? '0 : w_clr2 ? wb_data : w_rd2;
  assign w_rsp.rd       = w_req.rd;
  assign w_rsp.rd_we    = w_req.rd_we;

  assign w_wb_mask  = (wb_valid && wb_rd != '0) ? sb_vec_t'(1) << wb_rd : '0;
  assign w_set_mask = (w_acc && w_req.rd_we && w_req.rd != '0) ? sb_vec_t'(1) << w_req.rd : '0;

  // Set is OR'd after the clear so a new claim wins over a same-cycle writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb  <= '0;
      r_ov  <= 1'b0;
      r_rsp <= '0;
    end else begin
      r_sb <= (r_sb & ~w_wb_mask) | w_set_mask;
      if (w_acc) begin
        r_ov  <= 1'b1;
        r_rsp <= w_rsp;
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign out_valid    = r_ov;
  assign out_rs1_data = r_rsp.rs1_data;
  assign out_rs2_data = r_rsp.rs2_data;
  assign out_rd       = r_rsp.rd;
  assign out_rd_we    = r_rsp.rd_we;
  assign sb_busy      = r_sb;
endmodule
